// File: rtl/el2_pkg.sv
// el2_pkg
//   Shared types and constants for the DCCM port arbiter.
//   - el2_dccm_arb_owner_e : which requester owns an access (LSU or DMA)
//   - el2_dccm_arb_cmd_t   : command captured at the command stage
//   - legal range of the DMA starvation limit, plus its range-check helper
package el2_pkg;

    localparam int unsigned EL2_DCCM_BITS          = 16;
    localparam int unsigned EL2_FDATA_WIDTH        = 39;

    // Bounds for the DMA starvation limit; the counter is 4 bits wide.
    localparam int unsigned EL2_ARB_STARVE_MIN     = 1;
    localparam int unsigned EL2_ARB_STARVE_LIMIT   = 15;
    localparam int unsigned EL2_ARB_STARVE_CNT_W   = 4;

    typedef enum logic {
        ARB_LSU = 1'b0,
        ARB_DMA = 1'b1
    } el2_dccm_arb_owner_e;

    typedef struct packed {
        logic                         we;
        logic [EL2_DCCM_BITS-1:0]     addr;
        logic [EL2_FDATA_WIDTH-1:0]   wdata;
        el2_dccm_arb_owner_e          owner;
    } el2_dccm_arb_cmd_t;

    function automatic bit el2_arb_starve_max_ok(input int unsigned v);
        return (v >= EL2_ARB_STARVE_MIN) && (v <= EL2_ARB_STARVE_LIMIT);
    endfunction

endpackage

// File: rtl/el2_dccm_arb_starve_ctr.sv
// el2_dccm_arb_starve_ctr
//   Counts consecutive cycles in which a pending DMA request loses to the LSU.
//   Ports:
//     clk, rst         : clock, asynchronous active-high reset
//     dma_req_i        : DMA request (already masked by reset)
//     dma_gnt_i        : DMA granted this cycle -> clear
//     lsu_gnt_i        : LSU granted this cycle -> count a lost DMA cycle
//     starve_hit_o     : counter has reached STARVE_MAX; forces a DMA grant
module el2_dccm_arb_starve_ctr
    import el2_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req_i,
    input  logic dma_gnt_i,
    input  logic lsu_gnt_i,
    output logic starve_hit_o
);

    localparam logic [EL2_ARB_STARVE_CNT_W-1:0] MAX_C = STARVE_MAX[EL2_ARB_STARVE_CNT_W-1:0];

    logic [EL2_ARB_STARVE_CNT_W-1:0] cnt_q;
    logic [EL2_ARB_STARVE_CNT_W-1:0] cnt_d;

    // A dropped request restarts the count, so starvation is measured only
    // over an unbroken run of waiting cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (dma_gnt_i || !dma_req_i) begin
            cnt_d = '0;
        end else if (lsu_gnt_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_hit_o = (cnt_q == MAX_C);

endmodule

// File: rtl/el2_dccm_port_arb.sv
// el2_dccm_port_arb
//   Shares the single DCCM access port between the LSU (default priority) and
//   the DMA slave (starvation protected), registers the winning command onto
//   the DCCM pins and steers returned read data to the requester that owns it.
//   Ports:
//     clk, rst                      : clock, asynchronous active-high reset
//     lsu_/dma_ req,we,addr,wdata   : requester commands, held until granted
//     lsu_/dma_ gnt                 : combinational grants
//     lsu_/dma_ rvalid,rdata        : read response per requester
//     dccm_wren/rden/addr/wr_data   : registered DCCM command
//     dccm_rd_data                  : DCCM read data, one cycle after rden
module el2_dccm_port_arb
    import el2_pkg::*;
#(
    parameter int unsigned DCCM_BITS   = EL2_DCCM_BITS,
    parameter int unsigned FDATA_WIDTH = EL2_FDATA_WIDTH,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   lsu_req,
    input  logic                   lsu_we,
    input  logic [DCCM_BITS-1:0]   lsu_addr,
    input  logic [FDATA_WIDTH-1:0] lsu_wdata,
    input  logic                   dma_req,
    input  logic                   dma_we,
    input  logic [DCCM_BITS-1:0]   dma_addr,
    input  logic [FDATA_WIDTH-1:0] dma_wdata,
    output logic                   lsu_gnt,
    output logic                   dma_gnt,
    output logic                   lsu_rvalid,
    output logic [FDATA_WIDTH-1:0] lsu_rdata,
    output logic                   dma_rvalid,
    output logic [FDATA_WIDTH-1:0] dma_rdata,
    output logic                   dccm_wren,
    output logic                   dccm_rden,
    output logic [DCCM_BITS-1:0]   dccm_addr,
    output logic [FDATA_WIDTH-1:0] dccm_wr_data,
    input  logic [FDATA_WIDTH-1:0] dccm_rd_data
);

    // The command struct is sized by the package widths.
    if (!el2_arb_starve_max_ok(STARVE_MAX)) begin : g_bad_starve
        $error("el2_dccm_port_arb: STARVE_MAX out of range");
    end
    if (DCCM_BITS != EL2_DCCM_BITS || FDATA_WIDTH != EL2_FDATA_WIDTH) begin : g_bad_width
        $error("el2_dccm_port_arb: widths must match el2_pkg");
    end

    logic lsu_req_m;
    logic dma_req_m;
    logic starve_hit;
    logic any_gnt;

    el2_dccm_arb_cmd_t cmd_d;

    logic                    wren_q;
    logic                    rden_q;
    logic [DCCM_BITS-1:0]    addr_q;
    logic [FDATA_WIDTH-1:0]  wr_data_q;
    el2_dccm_arb_owner_e     c_owner_q;
    logic                    r_vld_q;
    el2_dccm_arb_owner_e     r_owner_q;

    // Requests are masked during reset so no grant can escape while rst is high.
    assign lsu_req_m = lsu_req & ~rst;
    assign dma_req_m = dma_req & ~rst;

    assign dma_gnt = dma_req_m & (~lsu_req_m | starve_hit);
    assign lsu_gnt = lsu_req_m & ~dma_gnt;
    assign any_gnt = lsu_gnt | dma_gnt;

    el2_dccm_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .dma_req_i   (dma_req_m),
        .dma_gnt_i   (dma_gnt),
        .lsu_gnt_i   (lsu_gnt),
        .starve_hit_o(starve_hit)
    );

    always_comb begin
        if (dma_gnt) begin
            cmd_d.we    = dma_we;
            cmd_d.addr  = dma_addr;
            cmd_d.wdata = dma_wdata;
            cmd_d.owner = ARB_DMA;
        end else begin
            cmd_d.we    = lsu_we;
            cmd_d.addr  = lsu_addr;
            cmd_d.wdata = lsu_wdata;
            cmd_d.owner = ARB_LSU;
        end
    end

    // Command stage feeds the DCCM pins; the response stage tracks which
    // requester the read data returning next cycle belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wren_q    <= 1'b0;
            rden_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
            c_owner_q <= ARB_LSU;
            r_vld_q   <= 1'b0;
            r_owner_q <= ARB_LSU;
        end else begin
            wren_q <= any_gnt & cmd_d.we;
            rden_q <= any_gnt & ~cmd_d.we;
            if (any_gnt) begin
                addr_q    <= cmd_d.addr;
                wr_data_q <= cmd_d.wdata;
                c_owner_q <= cmd_d.owner;
            end
            r_vld_q   <= rden_q;
            r_owner_q <= c_owner_q;
        end
    end

    assign dccm_wren    = wren_q;
    assign dccm_rden    = rden_q;
    assign dccm_addr    = addr_q;
    assign dccm_wr_data = wr_data_q;

    assign lsu_rvalid = r_vld_q & (r_owner_q == ARB_LSU);
    assign dma_rvalid = r_vld_q & (r_owner_q == ARB_DMA);
    assign lsu_rdata  = dccm_rd_data;
    assign dma_rdata  = dccm_rd_data;

endmodule
